// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus launch sequencer in front of the UART transmitter.
//   Host writes are buffered. Bytes are handed to the transmitter one at a
//   time as a one-cycle o_TX_DV pulse. The next byte is launched only after
//   the transmitter reports done and one cleanup cycle has passed.
//
// Build option:
//   UART_TX_FIFO_DROP_CNT_EN - when defined, o_Drop_Count counts writes that
//   were dropped because the FIFO was full. The count saturates at 255 and is
//   cleared only by reset. When undefined, o_Drop_Count is a constant 0.
//
// Ports:
//   i_Clock, i_Rst_L     clock (rising edge), async active-low reset
//   i_Wr_DV, i_Wr_Byte   host write strobe and data
//   i_Flush              synchronous FIFO clear
//   o_Full, o_Almost_Full, o_Empty, o_Count   occupancy flags and count
//   o_TX_DV, o_TX_Byte   launch pulse and byte to the transmitter
//   i_TX_Active          transmitter busy
//   i_TX_Done            transmitter completion pulse
//   o_Drop_Count         dropped-write counter
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for data and an idle transmitter; launches on entry condition
//   LAUNCH | o_TX_DV pulse cycle
//   BUSY   | byte in flight, waiting for i_TX_Done
//   GAP    | one cycle of transmitter cleanup before the next launch
module uart_tx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_DV,
  input  logic [7:0]             i_Wr_Byte,
  input  logic                   i_Flush,
  output logic                   o_Full,
  output logic                   o_Almost_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic [7:0]             o_Drop_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            wr_en;
  logic            pop;

  assign o_Count       = count;
  assign o_Full        = (count == CW'(DEPTH));
  assign o_Almost_Full = (count >= CW'(AF_LEVEL));
  assign o_Empty       = (count == '0);

  // A full FIFO refuses the write even if a pop frees a slot this cycle.
  assign wr_en = i_Wr_DV & ~o_Full & ~i_Flush;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        // Flush wins over a launch in the same cycle.
        if (!o_Empty && !i_TX_Active && !i_Flush) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = BUSY;
      BUSY:   if (i_TX_Done) state_nxt = GAP;
      GAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_ptr] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  // The byte register is held after the pulse and is not touched by flush,
  // so an in-flight byte stays visible until the next launch.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= 8'd0;
    end else begin
      o_TX_DV <= pop;
      if (pop) o_TX_Byte <= mem[rd_ptr];
    end
  end

`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;

  // A write that coincides with flush is discarded, not counted as a drop.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) drop_cnt <= 8'd0;
    else if (i_Wr_DV && o_Full && !i_Flush && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  assign o_Drop_Count = drop_cnt;
`else
  assign o_Drop_Count = 8'd0;
`endif

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the host side into a synchronous FIFO. It presents them one at a time to the transmitter's data-valid/byte inputs, then waits for the transmitter's done pulse before launching the next byte. This decouples bursty producers from the serial line rate.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >= 2.
AF_LEVEL, 12, o_Almost_Full asserts when occupancy >= AF_LEVEL; range 1..DEPTH.

Ports:
i_Clock  input  1  system clock; all logic on rising edge.
i_Rst_L  input  1  asynchronous active-low reset.
i_Wr_DV  input  1  write strobe; one byte per cycle high.
i_Wr_Byte  input  8  byte to enqueue.
i_Flush  input  1  synchronous FIFO clear.
o_Full  output  1  occupancy == DEPTH.
o_Almost_Full  output  1  occupancy >= AF_LEVEL.
o_Empty  output  1  occupancy == 0.
o_Count  output  $clog2(DEPTH)+1  current occupancy.
o_TX_DV  output  1  one-cycle launch pulse to transmitter.
o_TX_Byte  output  8  byte to transmitter; valid while o_TX_DV is high, held afterwards.
i_TX_Active  input  1  transmitter busy.
i_TX_Done  input  1  transmitter one-cycle completion pulse.
o_Drop_Count  output  8  dropped-write counter (see Optional Feature).

Behaviour:
- Reset is i_Rst_L, asynchronous, active-low; clock is i_Clock.
- Reset values: pointers, count, o_TX_DV, o_TX_Byte and o_Drop_Count are 0; o_Empty is 1; o_Full and o_Almost_Full are 0; FSM is in IDLE.
- Flags are combinational from the registered count. Pointers are $clog2(DEPTH) bits and wrap naturally. Count is one bit wider.
- Write: accepted when i_Wr_DV=1, o_Full=0 and i_Flush=0. Data is stored at wr_ptr, then wr_ptr++.
- Write while o_Full=1 is dropped, even if a pop occurs in the same cycle. Contents and pointers are unchanged.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, LAUNCH, BUSY, GAP.
- IDLE: if o_Empty=0 and i_TX_Active=0, then o_TX_DV<=1, o_TX_Byte<=mem[rd_ptr], rd_ptr++, count-- (pop), and go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: o_TX_DV<=0, go to BUSY. The o_TX_DV pulse is exactly 1 cycle.
- BUSY: on i_TX_Done=1 go to GAP; otherwise stay.
- GAP: go to IDLE after 1 cycle. This covers the transmitter's 1-cycle cleanup so the next launch never lands while the transmitter is not yet idle.
- Latency: write at edge N leaves o_Empty=0 after N. o_TX_DV is high after edge N+1. No bypass when empty.
- Spacing: done pulse sampled at edge M gives next o_TX_DV high after edge M+2 at the earliest.
- i_Flush=1: rd_ptr, wr_ptr and count go to 0 at the next edge. A write in the same cycle is dropped and not counted in o_Drop_Count. The in-flight byte is not aborted; the FSM state and o_TX_Byte are unaffected. A flush in IDLE suppresses a launch in that same cycle.
- Reset asserted mid-operation: everything returns to reset values immediately. No o_TX_DV is generated until a new write arrives after reset release.
- i_TX_Done outside BUSY is ignored.

Optional Feature:
- Macro UART_TX_FIFO_DROP_CNT_EN.
- Defined: o_Drop_Count increments by 1 on each write dropped because o_Full=1. It saturates at 255 and is cleared only by reset; i_Flush does not clear it.
- Undefined: o_Drop_Count is tied to 8'd0 and no counter register is built.

Test Plan:
1. DEPTH=4. Write 0xA5 at edge 0, with i_TX_Active=0 -> o_Empty=0 after edge 0; o_TX_DV=1 for exactly 1 cycle after edge 1 with o_TX_Byte=0xA5; o_Empty=1 again.
2. DEPTH=4, i_TX_Active held 1. Write 0x01..0x05 on consecutive cycles -> o_Full=1 after 4 writes; 0x05 dropped; o_Count=4; o_Drop_Count=1 (feature on) or 0 (feature off).
3. Queue 0x11, 0x22, 0x33. Return an i_TX_Done pulse 10 cycles after each o_TX_DV -> bytes launch in order. Each o_TX_DV is no earlier than 2 edges after the preceding done sample. No launch occurs in GAP.
4. DEPTH=4. Write and drain 11 bytes 0x00..0x0A -> output sequence is identical. Pointers wrap twice. o_Count never exceeds 4.
5. 3 bytes queued, FSM in BUSY. Pulse i_Flush together with a write of 0x77 -> o_Count=0 and o_Empty=1. The in-flight byte completes. After done+GAP no o_TX_DV occurs. 0x77 is never sent.
6. Assert i_Rst_L=0 while in BUSY with 2 bytes queued -> all outputs go to reset values asynchronously. After release, no o_TX_DV occurs until a new write.
